// File: rtl/alu_pkg.sv
// Shared opcode type and width helpers for the ALU/MAC pipeline.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_MUL   = 2'b01,
    OP_MAC   = 2'b10,
    OP_MACLD = 2'b11
  } op_e;

  // Helpers work on a wide scratch vector; callers truncate to their own width.
  localparam int unsigned ALU_MAX_W = 128;

  // Sign-extend the low w bits of v across the full scratch width.
  function automatic logic [ALU_MAX_W-1:0] sext(input logic [ALU_MAX_W-1:0] v,
                                                input int unsigned w);
    logic [ALU_MAX_W-1:0] r;
    r = v << (ALU_MAX_W - w);
    return $signed(r) >>> (ALU_MAX_W - w);
  endfunction

  // Largest positive value of a w-bit signed number.
  function automatic logic [ALU_MAX_W-1:0] acc_max(input int unsigned w);
    return (ALU_MAX_W'(1) << (w - 1)) - ALU_MAX_W'(1);
  endfunction

  // Most negative value of a w-bit signed number (sign-extended).
  function automatic logic [ALU_MAX_W-1:0] acc_min(input int unsigned w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/alu_mac_acc.sv
// Stage-3 accumulator: load or add a sign-extended product.
// Define ALU_SAT_EN to clip the add at the signed limits instead of wrapping.
module alu_mac_acc
  import alu_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [ACC_W-1:0] add_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_d;

`ifdef ALU_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           w_sat_d;
  logic           r_sat;

  always_comb begin
    w_sum   = {r_acc[ACC_W-1], r_acc} + {add_in[ACC_W-1], add_in};
    w_sat_d = 1'b0;
    w_acc_d = w_sum[ACC_W-1:0];
    // Top two bits disagree only when the signed add left the ACC_W range.
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_sat_d = 1'b1;
      w_acc_d = w_sum[ACC_W] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
    end
    if (load) begin
      w_sat_d = 1'b0;
      w_acc_d = add_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (en) begin
      r_sat <= w_sat_d;
    end
  end

  assign sat = r_sat;
`else
  always_comb begin
    w_acc_d = load ? add_in : r_acc + add_in;
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= w_acc_d;
    end
  end

  assign acc_out = r_acc;

endmodule

// File: rtl/alu_mac_pipe.sv
// Three-stage signed ADD/MUL/MAC/MACLD pipeline with valid/ready on both sides.
// Define ALU_SAT_EN to saturate the MAC accumulator instead of wrapping.
module alu_mac_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              sat
);

  localparam int unsigned PW = 2 * DATA_W;

  logic              w_adv;
  logic              r_v1, r_v2, r_v3;
  logic [DATA_W-1:0] r_a1, r_b1;
  op_e               r_op1, r_op2;
  logic [PW-1:0]     r_p2;
  logic [ACC_W-1:0]  r_result;
  logic              r_is_acc3;

  logic [DATA_W:0]   w_sum;
  logic [PW-1:0]     w_prod, w_p2_d;
  logic [ACC_W-1:0]  w_p3, w_acc_out;
  logic              w_is_acc2, w_acc_en, w_acc_load, w_acc_sat;

  // Everything moves together unless a held result is blocking the output.
  assign w_adv     = !(r_v3 && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_v3;

  always_comb begin
    w_sum  = {r_a1[DATA_W-1], r_a1} + {r_b1[DATA_W-1], r_b1};
    w_prod = {{DATA_W{r_a1[DATA_W-1]}}, r_a1} * {{DATA_W{r_b1[DATA_W-1]}}, r_b1};
    w_p2_d = (r_op1 == OP_ADD) ? PW'(sext(ALU_MAX_W'(w_sum), DATA_W + 1)) : w_prod;
  end

  assign w_p3       = ACC_W'(sext(ALU_MAX_W'(r_p2), PW));
  assign w_is_acc2  = (r_op2 == OP_MAC) || (r_op2 == OP_MACLD);
  assign w_acc_en   = w_adv && r_v2 && w_is_acc2;
  assign w_acc_load = (r_op2 == OP_MACLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_a1      <= '0;
      r_b1      <= '0;
      r_op1     <= OP_ADD;
      r_op2     <= OP_ADD;
      r_p2      <= '0;
      r_result  <= '0;
      r_is_acc3 <= 1'b0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_a1  <= a;
      r_b1  <= b;
      r_op1 <= op_e'(op_sel);
      r_v2  <= r_v1;
      r_p2  <= w_p2_d;
      r_op2 <= r_op1;
      r_v3  <= r_v2;
      // Bubbles leave the last result in place.
      if (r_v2) begin
        r_result  <= w_p3;
        r_is_acc3 <= w_is_acc2;
      end
    end
  end

  alu_mac_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en     (w_acc_en),
    .load   (w_acc_load),
    .add_in (w_p3),
    .acc_out(w_acc_out),
    .sat    (w_acc_sat)
  );

  // Accumulating beats report the accumulator itself, which is already registered.
  assign result = r_is_acc3 ? w_acc_out : r_result;
  assign sat    = r_is_acc3 && w_acc_sat;

endmodule

// File: tb/tb_alu_mac_pipe.sv
// Bench for alu_mac_pipe: 40-bit and 32-bit instances against a queue-based arithmetic model.
module tb_alu_mac_pipe;
  localparam int unsigned DW = 16;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] a, b;
  logic [1:0]  op_sel;
  logic        in_ready40, in_ready32, ov40, ov32, sat40, sat32;
  logic [39:0] res40;
  logic [31:0] res32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic signed [63:0] r40;
    logic signed [63:0] r32;
    bit                 s40;
    bit                 s32;
  } exp_t;

  exp_t               q[$];
  logic signed [63:0] got40[$];
  logic signed [63:0] got32[$];
  bit                 gotsat32[$];
  int                 gotcyc[$];
  longint             macc40 = 0;
  longint             macc32 = 0;
  longint             av, bv, p;
  exp_t               e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_mac_pipe u_dut40 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready40), .a(a), .b(b),
    .op_sel(op_sel), .out_valid(ov40), .out_ready(out_ready), .result(res40), .sat(sat40)
  );

  alu_mac_pipe #(.ACC_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
    .op_sel(op_sel), .out_valid(ov32), .out_ready(out_ready), .result(res32), .sat(sat32)
  );

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint x, input int w);
    longint sh = 64 - w;
    return (x <<< sh) >>> sh;
  endfunction

  function automatic longint acc_add(input longint acc, input longint pp, input int w,
                                     output bit s);
    longint sum = acc + pp;
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    s = 1'b0;
`ifdef ALU_SAT_EN
    if (sum > mx) begin s = 1'b1; return mx; end
    if (sum < -mx - 1) begin s = 1'b1; return -mx - 1; end
`endif
    return wrapw(sum, w);
  endfunction

  // Handshakes are evaluated mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      macc40 = 0;
      macc32 = 0;
    end else begin
      chk("in_ready40_rule", in_ready40, !(ov40 && !out_ready));
      chk("in_ready32_rule", in_ready32, !(ov32 && !out_ready));
      if (ov40 && out_ready) begin
        got40.push_back($signed(res40));
        got32.push_back($signed(res32));
        gotsat32.push_back(sat32);
        gotcyc.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("res40", $signed(res40), e.r40);
          chk("res32", $signed(res32), e.r32);
          chk("sat40", sat40, e.s40);
          chk("sat32", sat32, e.s32);
          chk("valid32", ov32, 1);
        end
      end
      if (in_valid && in_ready40) begin
        av = longint'($signed(a));
        bv = longint'($signed(b));
        p  = av * bv;
        e.s40 = 1'b0;
        e.s32 = 1'b0;
        case (op_sel)
          2'b00: begin e.r40 = av + bv; e.r32 = av + bv; end
          2'b01: begin e.r40 = p; e.r32 = p; end
          2'b10: begin
            macc40 = acc_add(macc40, p, 40, e.s40);
            macc32 = acc_add(macc32, p, 32, e.s32);
            e.r40 = macc40;
            e.r32 = macc32;
          end
          default: begin macc40 = p; macc32 = p; e.r40 = p; e.r32 = p; end
        endcase
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] op, input int x, input int y);
    int n = 0;
    in_valid = 1'b1;
    op_sel   = op;
    a        = 16'(x);
    b        = 16'(y);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready40 && n < 50);
    if (!in_ready40) chk("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
    tick();
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op_sel = '0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready40, 1);
    chk("rst_out_valid", ov40, 0);
    chk("rst_result", res40, 0);
    chk("rst_sat", sat40, 0);
    rst = 1'b0;
    tick();

    // ADD latency and single-cycle valid pulse
    beat(2'b00, 100, -30);
    chk("add_lat0", ov40, 0);
    tick();
    chk("add_lat1", ov40, 0);
    tick();
    chk("add_lat2", ov40, 1);
    chk("add_res40", $signed(res40), 70);
    chk("add_res32", $signed(res32), 70);
    tick();
    chk("add_pulse", ov40, 0);
    tick();

    base = got40.size();
    beat(2'b01, -32768, -32768);
    drain();
    chk("mul_full", got40[base], 64'sd1073741824);

    base = got40.size();
    beat(2'b11, 3, 4);
    beat(2'b10, 5, 6);
    beat(2'b10, -2, 7);
    drain();
    chk("mac_0", got40[base], 12);
    chk("mac_1", got40[base+1], 42);
    chk("mac_2", got40[base+2], 28);
    chk("mac_b2b_a", gotcyc[base+1] - gotcyc[base], 1);
    chk("mac_b2b_b", gotcyc[base+2] - gotcyc[base+1], 1);

    base = got40.size();
    beat(2'b11, 3, 4);
    beat(2'b10, 5, 6);
    beat(2'b00, 1, 1);
    beat(2'b10, -2, 7);
    drain();
    chk("mix_0", got40[base], 12);
    chk("mix_1", got40[base+1], 42);
    chk("mix_add", got40[base+2], 2);
    chk("mix_end", got40[base+3], 28);

    // Backpressure with three beats in flight
    base = got40.size();
    out_ready = 1'b0;
    beat(2'b00, 10, 1);
    beat(2'b01, 3, -5);
    beat(2'b11, 2, 3);
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_ready", in_ready40, 0);
      chk("stall_valid", ov40, 1);
      chk("stall_hold", $signed(res40), 11);
      tick();
    end
    out_ready = 1'b1;
    drain();
    chk("stall_count", got40.size() - base, 3);
    chk("stall_0", got40[base], 11);
    chk("stall_1", got40[base+1], -15);
    chk("stall_2", got40[base+2], 6);

    // Accumulator overflow: only the 32-bit instance leaves its range
    base = got40.size();
    beat(2'b11, 32767, 32767);
    for (int i = 0; i < 3; i++) beat(2'b10, 32767, 32767);
    drain();
    chk("ovf_40", got40[base+3], 64'sd4294705156);
    chk("ovf_32_1", got32[base+1], 64'sd2147352578);
`ifdef ALU_SAT_EN
    chk("ovf_32_2", got32[base+2], 64'sd2147483647);
    chk("ovf_32_3", got32[base+3], 64'sd2147483647);
    chk("ovf_sat_2", gotsat32[base+2], 1);
`else
    chk("ovf_32_2", got32[base+2], -64'sd1073938429);
    chk("ovf_32_3", got32[base+3], -64'sd262140);
    chk("ovf_sat_2", gotsat32[base+2], 0);
`endif

    // Reset with two MACs in flight
    base = got40.size();
    beat(2'b10, 5, 5);
    beat(2'b10, 6, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_flush", ov40, 0);
      tick();
    end
    chk("rst_none_out", got40.size() - base, 0);
    beat(2'b10, 2, 2);
    drain();
    chk("rst_acc40", got40[base], 4);
    chk("rst_acc32", got32[base], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
